uart_rx_controller: RTL and testbench

- Sits between uart_rx and the byte consumer.
- Drains received bytes from uart_rx into a small first-word-fall-through FIFO.
- Sequences the uart_rx acknowledge: a one-cycle pulse followed by a mandatory release cycle, because uart_rx clears ready only once per ack pulse.
- Applies back-pressure by withholding ack when the FIFO is full, and flags that condition for software.

---
 rtl/uart_rx_controller.sv | 128 ++++++++++++
 tb/tb_uart_rx_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_controller.sv
// Drains bytes from uart_rx into a small FWFT FIFO, sequencing the uart_rx ack
// as pulse-then-release and withholding ack (with a sticky stall flag) while full.
module uart_rx_controller #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 4,
  parameter int LEVEL_WIDTH = 3
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic                   clear_i,
  input  logic [DATA_WIDTH-1:0]  rx_data_i,
  input  logic                   rx_ready_i,
  output logic                   rx_ack_o,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [LEVEL_WIDTH-1:0] level_o,
  output logic                   stall_o,
  output logic [1:0]             state_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LEVEL_WIDTH-1:0] FULL = LEVEL_WIDTH'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACK     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                  state_q;
  logic                    ack_q;
  logic                    stall_q, stall_d;
  logic [LEVEL_WIDTH-1:0]  level_q, level_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic offer, capture, blocked, push, pop;

  // valid_o/ready_i handshake: the head byte transfers on every rising edge where
  // valid_o && ready_i; valid_o never depends on ready_i, and data_o is stable
  // while valid_o is high and no transfer has happened.
  assign offer   = (state_q == ST_IDLE) && rx_ready_i && enable_i;
  assign capture = offer && (level_q != FULL);
  assign blocked = offer && (level_q == FULL);
  assign push    = capture && !clear_i;
  assign pop     = valid_o && ready_i && !clear_i;

  always_comb begin
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    stall_d  = stall_q || blocked;
    if (clear_i) begin
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      stall_d  = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LEVEL_WIDTH'(1);
        2'b01:   level_d = level_q - LEVEL_WIDTH'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // The release cycle ignores rx_ready_i: uart_rx may still show the acked byte.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (capture) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
          end else begin
            ack_q   <= 1'b0;
          end
        end
        ST_ACK: begin
          state_q <= ST_RELEASE;
          ack_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= rx_data_i;
    end
  end

  assign rx_ack_o = ack_q;
  assign data_o   = mem_q[rd_ptr_q];
  assign valid_o  = (level_q != '0);
  assign level_o  = level_q;
  assign stall_o  = stall_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed, table-driven bench for uart_rx_controller: each record drives one
// clock of inputs and lists the outputs expected just after that edge.
module tb_uart_rx_controller;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b0;
  logic       enable_i = 1'b0;
  logic       clear_i = 1'b0;
  logic [7:0] rx_data_i = 8'h00;
  logic       rx_ready_i = 1'b0;
  logic       rx_ack_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic [2:0] level_o;
  logic       stall_o;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;
  logic prev_ack = 1'b0;

  uart_rx_controller #(.DATA_WIDTH(8), .DEPTH(4), .LEVEL_WIDTH(3)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .clear_i(clear_i),
    .rx_data_i(rx_data_i), .rx_ready_i(rx_ready_i), .rx_ack_o(rx_ack_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .level_o(level_o),
    .stall_o(stall_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clock_i = ~clock_i;

  typedef struct {
    logic       en, clr, rr;
    logic [7:0] rd;
    logic       rdy;
    logic       e_ack, e_valid;
    logic [7:0] e_data;
    logic [2:0] e_level;
    logic       e_stall;
  } vec_t;

  vec_t vecs[$];

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic en, input logic clr, input logic rr, input logic [7:0] rd,
                     input logic rdy, input logic e_ack, input logic e_valid,
                     input logic [7:0] e_data, input logic [2:0] e_level, input logic e_stall);
    vec_t v;
    v.en = en; v.clr = clr; v.rr = rr; v.rd = rd; v.rdy = rdy;
    v.e_ack = e_ack; v.e_valid = e_valid; v.e_data = e_data;
    v.e_level = e_level; v.e_stall = e_stall;
    vecs.push_back(v);
  endtask

  task automatic step(input vec_t v, input string tag);
    enable_i   = v.en;
    clear_i    = v.clr;
    rx_ready_i = v.rr;
    rx_data_i  = v.rd;
    ready_i    = v.rdy;
    @(posedge clock_i);
    #1;
    chk({tag, ".ack"},   32'(rx_ack_o), 32'(v.e_ack));
    chk({tag, ".valid"}, 32'(valid_o),  32'(v.e_valid));
    chk({tag, ".level"}, 32'(level_o),  32'(v.e_level));
    chk({tag, ".stall"}, 32'(stall_o),  32'(v.e_stall));
    if (v.e_valid) chk({tag, ".data"}, 32'(data_o), 32'(v.e_data));
  endtask

  // Ack pulses must be isolated by at least one low cycle.
  always @(negedge clock_i) begin
    if (reset_i && rx_ack_o) begin
      checks++;
      if (prev_ack) begin
        errors++;
        $display("FAIL ack_spacing: ack high in two consecutive cycles at %0t", $time);
      end
    end
    prev_ack = reset_i && rx_ack_o;
  end

  // ---------------- stimulus ----------------
  initial begin
    vec_t v;

    // single byte
    add(1,0,1,8'h55,0, 1,1,8'h55,1,0);
    add(1,0,0,8'h00,0, 0,1,8'h55,1,0);
    add(1,0,0,8'h00,0, 0,1,8'h55,1,0);
    add(1,0,0,8'h00,1, 0,0,8'h00,0,0);
    // back-to-back with rx_ready_i held high
    add(1,0,1,8'hAA,0, 1,1,8'hAA,1,0);
    add(1,0,1,8'hCC,0, 0,1,8'hAA,1,0);
    add(1,0,1,8'hCC,0, 0,1,8'hAA,1,0);
    add(1,0,1,8'hCC,0, 1,1,8'hAA,2,0);
    add(1,0,0,8'h00,0, 0,1,8'hAA,2,0);
    add(1,0,0,8'h00,0, 0,1,8'hAA,2,0);
    add(1,0,0,8'h00,1, 0,1,8'hCC,1,0);
    add(1,0,0,8'h00,1, 0,0,8'h00,0,0);
    // pop while empty, and offer while disabled
    add(1,0,0,8'h00,1, 0,0,8'h00,0,0);
    add(0,0,1,8'h99,0, 0,0,8'h00,0,0);
    // fill to DEPTH, then stall on the fifth byte
    for (int b = 1; b <= 4; b++) begin
      add(1,0,1,8'(b),0, 1,1,8'h01,3'(b),0);
      add(1,0,0,8'h00,0, 0,1,8'h01,3'(b),0);
      add(1,0,0,8'h00,0, 0,1,8'h01,3'(b),0);
    end
    add(1,0,1,8'h05,0, 0,1,8'h01,4,1);
    add(1,0,1,8'h05,0, 0,1,8'h01,4,1);
    add(1,0,1,8'h05,1, 0,1,8'h02,3,1);   // pop while full: no push this edge
    add(1,0,1,8'h05,0, 1,1,8'h02,4,1);
    add(1,0,0,8'h00,0, 0,1,8'h02,4,1);
    add(1,0,0,8'h00,0, 0,1,8'h02,4,1);
    add(1,0,0,8'h00,1, 0,1,8'h03,3,1);
    add(1,0,0,8'h00,1, 0,1,8'h04,2,1);
    add(1,0,0,8'h00,1, 0,1,8'h05,1,1);
    add(1,0,0,8'h00,1, 0,0,8'h00,0,1);
    // refill to 3 with stall set, then clear
    for (int k = 1; k <= 3; k++) begin
      add(1,0,1,8'(k*8'h11),0, 1,1,8'h11,3'(k),1);
      add(1,0,0,8'h00,0,     0,1,8'h11,3'(k),1);
      add(1,0,0,8'h00,0,     0,1,8'h11,3'(k),1);
    end
    add(1,1,0,8'h00,0, 0,0,8'h00,0,0);
    // capture in the clear cycle: acked but discarded
    add(1,1,1,8'h77,0, 1,0,8'h00,0,0);
    add(1,0,0,8'h00,0, 0,0,8'h00,0,0);
    add(1,0,0,8'h00,0, 0,0,8'h00,0,0);
    // simultaneous push and pop at level 2, wrapping pointers
    add(1,0,1,8'h41,0, 1,1,8'h41,1,0);
    add(1,0,0,8'h00,0, 0,1,8'h41,1,0);
    add(1,0,0,8'h00,0, 0,1,8'h41,1,0);
    add(1,0,1,8'h42,0, 1,1,8'h41,2,0);
    add(1,0,0,8'h00,0, 0,1,8'h41,2,0);
    add(1,0,0,8'h00,0, 0,1,8'h41,2,0);
    for (int j = 0; j < 4; j++) begin
      add(1,0,1,8'(8'h43 + j),1, 1,1,8'(8'h42 + j),2,0);
      add(1,0,0,8'h00,0,        0,1,8'(8'h42 + j),2,0);
      add(1,0,0,8'h00,0,        0,1,8'(8'h42 + j),2,0);
    end
    add(1,0,0,8'h00,1, 0,1,8'h46,1,0);
    add(1,0,0,8'h00,1, 0,0,8'h00,0,0);

    // reset state
    #12;
    chk("reset.ack",   32'(rx_ack_o), 0);
    chk("reset.valid", 32'(valid_o),  0);
    chk("reset.level", 32'(level_o),  0);
    chk("reset.stall", 32'(stall_o),  0);
    chk("reset.data",  32'(data_o),   0);
    chk("reset.state", 32'(state_o),  0);
    @(posedge clock_i);
    #1;
    reset_i = 1'b1;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // enable dropped during the ACK cycle
    v = '{en:1, clr:0, rr:1, rd:8'h5A, rdy:0, e_ack:1, e_valid:1, e_data:8'h5A, e_level:1, e_stall:0};
    step(v, "endrop.cap");
    chk("endrop.state_ack", 32'(state_o), 1);
    v = '{en:0, clr:0, rr:1, rd:8'h5B, rdy:0, e_ack:0, e_valid:1, e_data:8'h5A, e_level:1, e_stall:0};
    step(v, "endrop.rel");
    chk("endrop.state_rel", 32'(state_o), 2);
    for (int n = 0; n < 4; n++) step(v, $sformatf("endrop.hold%0d", n));
    chk("endrop.state_idle", 32'(state_o), 0);

    // asynchronous reset while the ack pulse is high
    v = '{en:1, clr:0, rr:1, rd:8'h5B, rdy:0, e_ack:1, e_valid:1, e_data:8'h5A, e_level:2, e_stall:0};
    step(v, "arst.cap");
    #2;
    reset_i = 1'b0;
    #1;
    chk("arst.ack",   32'(rx_ack_o), 0);
    chk("arst.valid", 32'(valid_o),  0);
    chk("arst.level", 32'(level_o),  0);
    chk("arst.state", 32'(state_o),  0);
    rx_ready_i = 1'b0;
    enable_i   = 1'b0;
    @(posedge clock_i);
    #1;
    reset_i = 1'b1;
    v = '{en:1, clr:0, rr:0, rd:8'h00, rdy:0, e_ack:0, e_valid:0, e_data:8'h00, e_level:0, e_stall:0};
    step(v, "arst.after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
